// File: rtl/key_tone_player.sv
// Piezo tone/melody player: a short note per key press, and three fixed melodies
// for the game's round-clear, game-clear and game-fail events.
module key_tone_player #(
    parameter int unsigned CLK_HZ  = 1_000_000,
    parameter int unsigned KEY_MS  = 80,
    parameter int unsigned NOTE_MS = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] current_key,
    input  logic       round_clear,
    input  logic       game_clear,
    input  logic       game_fail,
    output logic       piezo_out,
    output logic       busy
);

    // Half-period in cycles for notes C4..C5, rounded; frequencies are in centi-Hz.
    function automatic int unsigned half_period(input int unsigned idx);
        longint unsigned fc;
        case (idx)
            0:       fc = 64'd26163;
            1:       fc = 64'd29366;
            2:       fc = 64'd32963;
            3:       fc = 64'd34923;
            4:       fc = 64'd39200;
            5:       fc = 64'd44000;
            6:       fc = 64'd49388;
            default: fc = 64'd52325;
        endcase
        return 32'((64'(CLK_HZ) * 64'd100 + fc) / (64'd2 * fc));
    endfunction

    localparam int unsigned HP_TABLE [8] = '{
        half_period(0), half_period(1), half_period(2), half_period(3),
        half_period(4), half_period(5), half_period(6), half_period(7)
    };
    // C4 has the longest half-period, so it sizes the counter.
    localparam int unsigned HP_MAX = half_period(0);
    localparam int unsigned HP_W   = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;
    localparam int unsigned TICK   = CLK_HZ / 1000;
    localparam int unsigned PRE_W  = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int unsigned MS_MAX = (KEY_MS > NOTE_MS) ? KEY_MS : NOTE_MS;
    localparam int unsigned MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

    typedef enum logic [1:0] {StIdle, StKey, StMelody} state_e;

    // Note index for a given melody id (1 round, 2 game clear, 3 fail) and step.
    function automatic logic [2:0] mel_note(input logic [1:0] id, input logic [1:0] step);
        logic [2:0] n;
        n = 3'd0;
        case (id)
            2'd1: n = (step == 2'd0) ? 3'd4 : 3'd7;
            2'd2: begin
                case (step)
                    2'd0:    n = 3'd0;
                    2'd1:    n = 3'd2;
                    2'd2:    n = 3'd4;
                    default: n = 3'd7;
                endcase
            end
            2'd3: begin
                case (step)
                    2'd0:    n = 3'd7;
                    2'd1:    n = 3'd4;
                    default: n = 3'd0;
                endcase
            end
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] mel_last(input logic [1:0] id);
        case (id)
            2'd1:    return 2'd1;
            2'd2:    return 2'd3;
            2'd3:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        mel_id_q, mel_id_d;
    logic [1:0]        step_q, step_d;
    logic [2:0]        note_q, note_d;
    logic [HP_W-1:0]   hp_cnt_q, hp_cnt_d;
    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic              piezo_q, piezo_d;
    logic [3:0]        prev_q, prev_d;
    logic              arm_q, arm_d;

    logic [3:0]        in_now;
    logic [3:0]        rise;
    logic [1:0]        req;
    logic              start_mel;
    logic              start_key;
    logic [HP_W-1:0]   hp_last;
    logic [MS_W-1:0]   dur_last;

    // Bit order doubles as priority order: fail > game clear > round clear > key.
    assign in_now = {game_fail, game_clear, round_clear, key_valid};
    // arm_q masks the first clock after reset so a level already high is not a rise.
    assign rise   = in_now & ~prev_q & {4{arm_q}};

    // Request arbitration and next-state for tone sequencing.
    always_comb begin
        state_d   = state_q;
        mel_id_d  = mel_id_q;
        step_d    = step_q;
        note_d    = note_q;
        hp_cnt_d  = hp_cnt_q;
        pre_cnt_d = pre_cnt_q;
        ms_cnt_d  = ms_cnt_q;
        piezo_d   = piezo_q;
        prev_d    = in_now;
        arm_d     = 1'b1;

        if (rise[3])      req = 2'd3;
        else if (rise[2]) req = 2'd2;
        else if (rise[1]) req = 2'd1;
        else              req = 2'd0;

        start_mel = (req != 2'd0) && ((state_q != StMelody) || (req > mel_id_q));
        start_key = !start_mel && rise[0] && !current_key[3] && (state_q != StMelody);
        hp_last   = HP_W'(HP_TABLE[note_q] - 32'd1);
        dur_last  = (state_q == StKey) ? MS_W'(KEY_MS - 1) : MS_W'(NOTE_MS - 1);

        if (start_mel) begin
            state_d   = StMelody;
            mel_id_d  = req;
            step_d    = 2'd0;
            note_d    = mel_note(req, 2'd0);
            hp_cnt_d  = '0;
            pre_cnt_d = '0;
            ms_cnt_d  = '0;
            piezo_d   = 1'b0;
        end else if (start_key) begin
            state_d   = StKey;
            mel_id_d  = 2'd0;
            step_d    = 2'd0;
            note_d    = current_key[2:0];
            hp_cnt_d  = '0;
            pre_cnt_d = '0;
            ms_cnt_d  = '0;
            piezo_d   = 1'b0;
        end else if (state_q != StIdle) begin
            if (hp_cnt_q == hp_last) begin
                hp_cnt_d = '0;
                piezo_d  = ~piezo_q;
            end else begin
                hp_cnt_d = hp_cnt_q + HP_W'(1);
            end
            if (pre_cnt_q == PRE_W'(TICK - 1)) begin
                pre_cnt_d = '0;
                if (ms_cnt_q == dur_last) begin
                    // Current note is over: advance the melody or fall silent.
                    ms_cnt_d = '0;
                    hp_cnt_d = '0;
                    piezo_d  = 1'b0;
                    if ((state_q == StMelody) && (step_q != mel_last(mel_id_q))) begin
                        step_d = step_q + 2'd1;
                        note_d = mel_note(mel_id_q, step_q + 2'd1);
                    end else begin
                        state_d  = StIdle;
                        mel_id_d = 2'd0;
                        step_d   = 2'd0;
                        note_d   = 3'd0;
                    end
                end else begin
                    ms_cnt_d = ms_cnt_q + MS_W'(1);
                end
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mel_id_q  <= 2'd0;
            step_q    <= 2'd0;
            note_q    <= 3'd0;
            hp_cnt_q  <= '0;
            pre_cnt_q <= '0;
            ms_cnt_q  <= '0;
            piezo_q   <= 1'b0;
            prev_q    <= 4'd0;
            arm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mel_id_q  <= mel_id_d;
            step_q    <= step_d;
            note_q    <= note_d;
            hp_cnt_q  <= hp_cnt_d;
            pre_cnt_q <= pre_cnt_d;
            ms_cnt_q  <= ms_cnt_d;
            piezo_q   <= piezo_d;
            prev_q    <= prev_d;
            arm_q     <= arm_d;
        end
    end

    assign piezo_out = piezo_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_key_tone_player.sv
// Bench for key_tone_player: directed scenarios plus random traffic, each checked
// cycle by cycle against a queue-based model of the sound schedule.
module tb_key_tone_player;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] current_key = 4'd0;
    logic       round_clear = 1'b0;
    logic       game_clear = 1'b0;
    logic       game_fail = 1'b0;
    logic       piezo_out;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    key_tone_player #(
        .CLK_HZ (1_000_000),
        .KEY_MS (2),
        .NOTE_MS(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .current_key(current_key),
        .round_clear(round_clear),
        .game_clear (game_clear),
        .game_fail  (game_fail),
        .piezo_out  (piezo_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Model: a sounding note is (half-period, cycles since it began, length),
    // with any remaining melody notes waiting in a queue.
    localparam int HPT [8] = '{1911, 1703, 1517, 1432, 1276, 1136, 1012, 956};
    localparam int KEY_CYC  = 2000;
    localparam int NOTE_CYC = 3000;

    bit       m_active;
    bit       m_is_mel;
    int       m_mel;
    int       m_t;
    int       m_len;
    int       m_hp;
    int       m_q[$];
    bit [3:0] m_prev;
    bit       m_armed;

    function automatic void model_reset();
        m_active = 0; m_is_mel = 0; m_mel = 0; m_t = 0; m_len = 0; m_hp = 1;
        m_q.delete(); m_prev = 4'd0; m_armed = 0;
    endfunction

    function automatic void model_update();
        bit [3:0] in_now;
        bit [3:0] r;
        int req;
        if (!rst_n) begin
            model_reset();
            return;
        end
        in_now = {game_fail, game_clear, round_clear, key_valid};
        r = m_armed ? (in_now & ~m_prev) : 4'd0;
        req = r[3] ? 3 : r[2] ? 2 : r[1] ? 1 : 0;
        if (req != 0 && (!m_active || !m_is_mel || req > m_mel)) begin
            m_q.delete();
            case (req)
                1:       m_q = '{4, 7};
                2:       m_q = '{0, 2, 4, 7};
                default: m_q = '{7, 4, 0};
            endcase
            m_active = 1; m_is_mel = 1; m_mel = req;
            m_hp = HPT[m_q.pop_front()]; m_t = 0; m_len = NOTE_CYC;
        end else if (r[0] && current_key < 8 && !(m_active && m_is_mel)) begin
            m_active = 1; m_is_mel = 0; m_mel = 0;
            m_hp = HPT[current_key]; m_t = 0; m_len = KEY_CYC;
        end else if (m_active) begin
            m_t++;
            if (m_t == m_len) begin
                if (m_is_mel && m_q.size() > 0) begin
                    m_hp = HPT[m_q.pop_front()];
                    m_t = 0;
                end else begin
                    m_active = 0; m_is_mel = 0; m_mel = 0;
                end
            end
        end
        m_prev = in_now;
        m_armed = 1;
    endfunction

    function automatic logic exp_piezo();
        if (!m_active) return 1'b0;
        return ((m_t / m_hp) % 2) == 1;
    endfunction

    // Advance one clock; outputs are stable at the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if (busy !== 1'b0 || piezo_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state busy=%b piezo=%b, expected busy=0 piezo=0", busy, piezo_out);
        end
        model_reset();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (busy !== 1'b0 || piezo_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d busy=%b piezo=%b, expected 0 0", i, busy, piezo_out);
            end
        end
    endtask

    task automatic test_key_tone();
        bit bad;
        int first_tog;
        int end_cyc;
        bad = 0; first_tog = -1; end_cyc = -1;
        current_key = 4'd5; key_valid = 1'b1;
        for (int i = 0; i < 2100; i++) begin
            tick();
            key_valid = 1'b0;
            if (!bad) begin
                n_tests++;
                if (busy !== m_active || piezo_out !== exp_piezo()) begin
                    n_fail++; bad = 1;
                    $display("FAIL key_tone cyc=%0d busy=%b piezo=%b, expected busy=%b piezo=%b",
                             i, busy, piezo_out, m_active, exp_piezo());
                end
            end
            if (first_tog < 0 && piezo_out === 1'b1) first_tog = i;
            if (end_cyc < 0 && busy !== 1'b1) end_cyc = i;
        end
        n_tests++;
        if (first_tog != 1136) begin
            n_fail++;
            $display("FAIL key_first_toggle got cyc %0d, expected 1136", first_tog);
        end
        n_tests++;
        if (end_cyc != 2000) begin
            n_fail++;
            $display("FAIL key_duration busy fell at cyc %0d, expected 2000", end_cyc);
        end
    endtask

    task automatic test_illegal_key();
        current_key = 4'd9; key_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            key_valid = 1'b0;
            n_tests++;
            if (busy !== 1'b0 || piezo_out !== 1'b0 || m_active) begin
                n_fail++;
                $display("FAIL illegal_key cyc=%0d busy=%b piezo=%b, expected 0 0", i, busy, piezo_out);
                break;
            end
        end
    endtask

    task automatic test_round_clear();
        bit bad;
        int busy_cnt;
        bad = 0; busy_cnt = 0;
        round_clear = 1'b1;
        for (int i = 0; i < 6100; i++) begin
            tick();
            round_clear = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (!bad) begin
                n_tests++;
                if (busy !== m_active || piezo_out !== exp_piezo()) begin
                    n_fail++; bad = 1;
                    $display("FAIL round_clear cyc=%0d busy=%b piezo=%b, expected busy=%b piezo=%b",
                             i, busy, piezo_out, m_active, exp_piezo());
                end
            end
        end
        n_tests++;
        if (busy_cnt != 6000) begin
            n_fail++;
            $display("FAIL round_clear_len busy cycles %0d, expected 6000", busy_cnt);
        end
    endtask

    task automatic test_priority();
        bit bad;
        int busy_cnt;
        bad = 0; busy_cnt = 0;
        round_clear = 1'b1; game_fail = 1'b1;
        for (int i = 0; i < 9100; i++) begin
            tick();
            round_clear = 1'b0; game_fail = 1'b0; game_clear = 1'b0; key_valid = 1'b0;
            if (i == 2000) game_clear = 1'b1;
            if (i == 4000) begin key_valid = 1'b1; current_key = 4'd1; end
            if (busy === 1'b1) busy_cnt++;
            if (!bad) begin
                n_tests++;
                if (busy !== m_active || piezo_out !== exp_piezo()) begin
                    n_fail++; bad = 1;
                    $display("FAIL priority cyc=%0d busy=%b piezo=%b, expected busy=%b piezo=%b",
                             i, busy, piezo_out, m_active, exp_piezo());
                end
            end
        end
        n_tests++;
        if (busy_cnt != 9000) begin
            n_fail++;
            $display("FAIL fail_melody_len busy cycles %0d, expected 9000", busy_cnt);
        end
    endtask

    task automatic test_preempt();
        bit bad;
        int busy_cnt;
        bad = 0; busy_cnt = 0;
        game_clear = 1'b1;
        for (int i = 0; i < 9600; i++) begin
            tick();
            game_clear = 1'b0; game_fail = 1'b0;
            if (i == 499) game_fail = 1'b1;
            if (busy === 1'b1) busy_cnt++;
            if (!bad) begin
                n_tests++;
                if (busy !== m_active || piezo_out !== exp_piezo()) begin
                    n_fail++; bad = 1;
                    $display("FAIL preempt cyc=%0d busy=%b piezo=%b, expected busy=%b piezo=%b",
                             i, busy, piezo_out, m_active, exp_piezo());
                end
            end
        end
        n_tests++;
        if (busy_cnt != 9500) begin
            n_fail++;
            $display("FAIL preempt_len busy cycles %0d, expected 9500", busy_cnt);
        end
    endtask

    task automatic test_key_restart();
        bit bad;
        int busy_cnt;
        bad = 0; busy_cnt = 0;
        current_key = 4'd0; key_valid = 1'b1;
        for (int i = 0; i < 3100; i++) begin
            tick();
            key_valid = 1'b0;
            if (i == 999) begin key_valid = 1'b1; current_key = 4'd2; end
            if (busy === 1'b1) busy_cnt++;
            if (!bad) begin
                n_tests++;
                if (busy !== m_active || piezo_out !== exp_piezo()) begin
                    n_fail++; bad = 1;
                    $display("FAIL key_restart cyc=%0d busy=%b piezo=%b, expected busy=%b piezo=%b",
                             i, busy, piezo_out, m_active, exp_piezo());
                end
            end
        end
        n_tests++;
        if (busy_cnt != 3000) begin
            n_fail++;
            $display("FAIL key_restart_len busy cycles %0d, expected 3000", busy_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        bad = 0;
        round_clear = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            tick();
            round_clear = 1'b0;
        end
        round_clear = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (busy !== 1'b0 || piezo_out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset busy=%b piezo=%b, expected 0 0", busy, piezo_out);
        end
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6300; i++) begin
            tick();
            if (i == 200) round_clear = 1'b0;
            if (i == 210) round_clear = 1'b1;
            if (i == 211) round_clear = 1'b0;
            if (!bad) begin
                n_tests++;
                if (busy !== m_active || piezo_out !== exp_piezo()) begin
                    n_fail++; bad = 1;
                    $display("FAIL reset_release cyc=%0d busy=%b piezo=%b, expected busy=%b piezo=%b",
                             i, busy, piezo_out, m_active, exp_piezo());
                end
            end
            if (i == 100) begin
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL held_level_no_rise busy=%b, expected 0", busy);
                end
            end
            if (i == 212) begin
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fresh_rise_after_reset busy=%b, expected 1", busy);
                end
            end
        end
    endtask

    task automatic test_random();
        bit bad;
        bit drained;
        bad = 0; drained = 0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(149) == 0) key_valid = ~key_valid;
            if ($urandom_range(1999) == 0) round_clear = ~round_clear;
            if ($urandom_range(2999) == 0) game_clear = ~game_clear;
            if ($urandom_range(3999) == 0) game_fail = ~game_fail;
            current_key = 4'($urandom_range(15));
            tick();
            if (!bad) begin
                n_tests++;
                if (busy !== m_active || piezo_out !== exp_piezo()) begin
                    n_fail++; bad = 1;
                    $display("FAIL random cyc=%0d busy=%b piezo=%b, expected busy=%b piezo=%b",
                             i, busy, piezo_out, m_active, exp_piezo());
                end
            end
        end
        key_valid = 1'b0; round_clear = 1'b0; game_clear = 1'b0; game_fail = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            tick();
            if (!bad) begin
                n_tests++;
                if (busy !== m_active || piezo_out !== exp_piezo()) begin
                    n_fail++; bad = 1;
                    $display("FAIL random_drain cyc=%0d busy=%b piezo=%b, expected busy=%b piezo=%b",
                             i, busy, piezo_out, m_active, exp_piezo());
                end
            end
            if (!m_active && busy === 1'b0) begin
                drained = 1;
                break;
            end
        end
        n_tests++;
        if (!drained) begin
            n_fail++;
            $display("FAIL random_drain_timeout busy=%b, expected 0 within budget", busy);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_key_tone();
        test_illegal_key();
        test_round_clear();
        test_priority();
        test_preempt();
        test_key_restart();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_tone_player.md
KEY_TONE_PLAYER -- requirements
Module: key_tone_player

Interface
REQ-001 Parameter CLK_HZ, default 1_000_000: system clock frequency in Hz.
REQ-002 Parameter KEY_MS, default 80: key-click tone duration in ms.
REQ-003 Parameter NOTE_MS, default 120: duration of each melody note in ms.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 key_valid  input  1  pulse or level from the input-sync stage; a rising edge requests a key tone.
REQ-007 current_key  input  4  key index qualifying key_valid; only 0..7 are legal.
REQ-008 round_clear  input  1  from the game FSM; a rising edge requests the round-clear melody.
REQ-009 game_clear  input  1  from the game FSM; a rising edge requests the game-clear melody.
REQ-010 game_fail  input  1  from the game FSM; a rising edge requests the fail melody.
REQ-011 piezo_out  output  1  square-wave drive to the piezo buzzer.
REQ-012 busy  output  1  high while any tone or melody is sounding.

Function
REQ-013 Note table, indices 0..7 = C4 D4 E4 F4 G4 A4 B4 C5; half-period = round(CLK_HZ/(2*f)); CLK_HZ=1e6 gives 1911, 1703, 1517, 1432, 1276, 1136, 1012, 956 cycles.
REQ-014 Each input passes through a 1-flop edge detector; rise = in AND NOT in_prev.
REQ-015 A rise sampled in cycle N takes effect at the clock edge ending cycle N; the new state, busy and counter values are visible in cycle N+1.
REQ-016 The state machine has three states, IDLE, KEY and MELODY, plus a 2-bit mel_id register: 0 = none, 1 = round_clear, 2 = game_clear, 3 = game_fail.
REQ-017 Melodies are: round_clear = notes 4,7; game_clear = notes 0,2,4,7; game_fail = notes 7,4,0. Each note lasts NOTE_MS, with no gap between notes.
REQ-018 Priority is game_fail > game_clear > round_clear > key_valid; on simultaneous rises only the highest-priority request is accepted.
REQ-019 In IDLE or KEY, an accepted melody rise enters MELODY at note 0 of that melody and aborts any key tone.
REQ-020 In MELODY, a melody rise of strictly higher priority restarts at note 0 of the new melody; a rise of equal or lower priority is ignored.
REQ-021 key_valid rises are ignored while in MELODY.
REQ-022 In IDLE, a key_valid rise with current_key <= 7 enters KEY with note = current_key; current_key >= 8 is ignored.
REQ-023 In KEY, a new legal key_valid rise restarts KEY with the new note and a full KEY_MS duration.
REQ-024 Duration is counted with a 1 ms tick prescaler (CLK_HZ/1000 cycles) plus an ms counter. KEY lasts exactly KEY_MS*CLK_HZ/1000 cycles and each melody note exactly NOTE_MS*CLK_HZ/1000 cycles, measured from the entry edge.
REQ-025 On every tone start, note change or restart: the half-period counter and prescaler clear to 0, and piezo_out = 0.
REQ-026 piezo_out toggles on the cycle the half-period counter reaches half-period-1; the counter then wraps to 0.
REQ-027 When KEY expires or the last melody note expires: state -> IDLE, piezo_out = 0, busy = 0, mel_id = 0, all counters = 0, on the same edge.
REQ-028 In IDLE, piezo_out is held 0. busy = 1 exactly when state != IDLE.
REQ-029 Counter widths are sized from parameters so that no counter wraps early at the maximum parameter values.

Reset
REQ-030 While rst_n = 0, asynchronously: state = IDLE, piezo_out = 0, busy = 0, mel_id = 0, and all counters and edge-detect flops = 0.
REQ-031 Reset asserted mid-tone or mid-melody aborts it immediately; no sound resumes after release.
REQ-032 After release, an input already high does not count as a rise, because the edge flops reset to 0 and capture it on the first clock. The first rise accepted is a fresh low->high transition.

Verification (CLK_HZ=1e6, KEY_MS=2, NOTE_MS=3)
REQ-033 key_valid pulse with current_key=5 -> busy=1 from the next cycle; piezo_out toggles every 1136 cycles, first toggle 1136 cycles after entry; busy=0 and piezo_out=0 exactly 2000 cycles after entry.
REQ-034 key_valid with current_key=9 -> busy stays 0, piezo_out stays 0.
REQ-035 round_clear rise -> note 4 (half-period 1276) for 3000 cycles, then note 7 (half-period 956) for 3000 cycles, then IDLE; total busy time 6000 cycles.
REQ-036 Same-cycle rises of round_clear and game_fail -> fail melody 7,4,0, total 9000 cycles. game_clear rise during the fail melody -> ignored. game_fail rise 500 cycles into the game_clear melody -> restarts at the fail note 7.
REQ-037 key_valid rises at cycle 0 (key 0) and at cycle 1000 (key 2) -> the tone switches to half-period 1517 at cycle 1001 and ends 2000 cycles later. key_valid during a melody -> no change.
REQ-038 rst_n pulled low mid-melody -> piezo_out = 0 and busy = 0 asynchronously. Release with round_clear held high -> no melody until round_clear falls and rises again.
